imgproc_msg_reader: RTL and testbench

- Avalon-MM master that drives the image processor's memory-mapped message port from the other end, in hardware, with no CPU involved.
- After reset it checks the processor ID and flushes stale messages.
- It then polls the status register, drains the message FIFO and parses each 3-word "RBB" bounding-box message.
- Decoded boxes go out on a registered output bus with a one-cycle valid pulse, for the rover control logic.

---
 rtl/imgproc_msg_pkg.sv | 32 +++
 rtl/imgproc_msg_parser.sv | 69 ++++++
 rtl/imgproc_msg_reader.sv | 156 +++++++++++++++
 tb/tb_imgproc_msg_reader.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imgproc_msg_pkg.sv
// Shared constants and state encoding for the image-processor message reader.
// Covers the slave register map, status register fields and message identifiers.
package imgproc_msg_pkg;

    localparam logic [2:0] ADDR_STATUS = 3'd0;
    localparam logic [2:0] ADDR_MSG    = 3'd1;
    localparam logic [2:0] ADDR_ID     = 3'd2;
    localparam logic [2:0] ADDR_BBCOL  = 3'd3;

    localparam int STAT_FLUSH_BIT  = 4;
    localparam int STAT_COUNT_LSB  = 8;
    localparam int STAT_COUNT_MSB  = 15;

    localparam logic [31:0] STAT_FLUSH_WORD = 32'h1 << STAT_FLUSH_BIT;

    localparam logic [31:0] RBB_ID      = 32'h0052_4242;
    localparam logic [31:0] EXPECTED_ID = 32'h1234_EEE2;

    typedef enum logic [3:0] {
        ST_RESET,
        ST_ID_RD,
        ST_ID_WAIT,
        ST_HALT,
        ST_FLUSH,
        ST_POLL_WAIT,
        ST_STAT_RD,
        ST_STAT_WAIT,
        ST_MSG_RD,
        ST_MSG_WAIT
    } state_t;

endpackage

// File: rtl/imgproc_msg_parser.sv
// Parses the drained message word stream into bounding boxes.
// Word index survives across polls so a message split over two drains still completes.
module imgproc_msg_parser
    import imgproc_msg_pkg::*;
#(
    parameter logic [31:0] HEADER_ID = imgproc_msg_pkg::RBB_ID
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] word,
    input  logic        word_valid,
    output logic        bb_valid,
    output logic [10:0] bb_x_min,
    output logic [10:0] bb_y_min,
    output logic [10:0] bb_x_max,
    output logic [10:0] bb_y_max,
    output logic        bb_empty,
    output logic [7:0]  err_count
);

    logic [1:0]  idx;
    logic [10:0] x_min_hold;
    logic [10:0] y_min_hold;

    // Non-header words at index 0 are dropped and counted; the index stays put to resync.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx        <= 2'd0;
            x_min_hold <= '0;
            y_min_hold <= '0;
            err_count  <= '0;
            bb_valid   <= 1'b0;
            bb_x_min   <= '0;
            bb_y_min   <= '0;
            bb_x_max   <= '0;
            bb_y_max   <= '0;
            bb_empty   <= 1'b0;
        end else begin
            bb_valid <= 1'b0;
            if (word_valid) begin
                case (idx)
                    2'd0: begin
                        if (word == HEADER_ID) begin
                            idx <= 2'd1;
                        end else if (err_count != 8'hFF) begin
                            err_count <= err_count + 8'd1;
                        end
                    end
                    2'd1: begin
                        x_min_hold <= word[26:16];
                        y_min_hold <= word[10:0];
                        idx        <= 2'd2;
                    end
                    2'd2: begin
                        bb_x_min <= x_min_hold;
                        bb_y_min <= y_min_hold;
                        bb_x_max <= word[26:16];
                        bb_y_max <= word[10:0];
                        bb_empty <= (x_min_hold > word[26:16]);
                        bb_valid <= 1'b1;
                        idx      <= 2'd0;
                    end
                    default: idx <= 2'd0;
                endcase
            end
        end
    end

endmodule

// File: rtl/imgproc_msg_reader.sv
// Avalon-MM master that checks the image processor ID, flushes its FIFO,
// then periodically drains bounding-box messages into a registered output bus.
module imgproc_msg_reader
#(
    parameter int          POLL_CYCLES = 1000,
    parameter logic [31:0] EXPECTED_ID = imgproc_msg_pkg::EXPECTED_ID,
    parameter logic [31:0] RBB_ID      = imgproc_msg_pkg::RBB_ID
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    output logic        m_chipselect,
    output logic        m_read,
    output logic        m_write,
    output logic [2:0]  m_address,
    output logic [31:0] m_writedata,
    input  logic [31:0] m_readdata,
    output logic        id_ok,
    output logic        bb_valid,
    output logic [10:0] bb_x_min,
    output logic [10:0] bb_y_min,
    output logic [10:0] bb_x_max,
    output logic [10:0] bb_y_max,
    output logic        bb_empty,
    output logic [7:0]  err_count
);

    import imgproc_msg_pkg::*;

    localparam logic [15:0] POLL_LOAD = 16'(POLL_CYCLES - 1);

    state_t      state;
    state_t      next_state;
    logic [15:0] poll_cnt;
    logic [7:0]  pending;
    logic [7:0]  avail;
    logic        word_valid;
    logic        nxt_read;
    logic        nxt_write;
    logic [2:0]  nxt_addr;
    logic [31:0] nxt_wdata;

    assign avail = m_readdata[STAT_COUNT_MSB:STAT_COUNT_LSB];

    // Bus strobes are decoded from the next state so they are registered and
    // line up exactly with the *_RD / FLUSH states.
    always_comb begin
        next_state = state;
        word_valid = 1'b0;
        nxt_read   = 1'b0;
        nxt_write  = 1'b0;
        nxt_addr   = ADDR_STATUS;
        nxt_wdata  = '0;

        case (state)
            ST_RESET:     next_state = ST_ID_RD;
            ST_ID_RD:     next_state = ST_ID_WAIT;
            ST_ID_WAIT:   next_state = (m_readdata == EXPECTED_ID) ? ST_FLUSH : ST_HALT;
            ST_HALT:      next_state = ST_HALT;
            ST_FLUSH:     next_state = ST_POLL_WAIT;
            ST_POLL_WAIT: begin
                if (poll_cnt == 16'd0 && enable) begin
                    next_state = ST_STAT_RD;
                end
            end
            ST_STAT_RD:   next_state = ST_STAT_WAIT;
            ST_STAT_WAIT: next_state = (avail == 8'd0) ? ST_POLL_WAIT : ST_MSG_RD;
            ST_MSG_RD:    next_state = ST_MSG_WAIT;
            ST_MSG_WAIT: begin
                word_valid = 1'b1;
                next_state = (pending == 8'd1) ? ST_POLL_WAIT : ST_MSG_RD;
            end
            default:      next_state = ST_RESET;
        endcase

        case (next_state)
            ST_ID_RD: begin
                nxt_read = 1'b1;
                nxt_addr = ADDR_ID;
            end
            ST_FLUSH: begin
                nxt_write = 1'b1;
                nxt_addr  = ADDR_STATUS;
                nxt_wdata = STAT_FLUSH_WORD;
            end
            ST_STAT_RD: begin
                nxt_read = 1'b1;
                nxt_addr = ADDR_STATUS;
            end
            ST_MSG_RD: begin
                nxt_read = 1'b1;
                nxt_addr = ADDR_MSG;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_RESET;
            m_read       <= 1'b0;
            m_write      <= 1'b0;
            m_chipselect <= 1'b0;
            m_address    <= '0;
            m_writedata  <= '0;
            id_ok        <= 1'b0;
        end else begin
            state        <= next_state;
            m_read       <= nxt_read;
            m_write      <= nxt_write;
            m_chipselect <= nxt_read | nxt_write;
            m_address    <= nxt_addr;
            m_writedata  <= nxt_wdata;
            if (state == ST_ID_WAIT && next_state == ST_FLUSH) begin
                id_ok <= 1'b1;
            end
        end
    end

    // Poll counter reloads on every entry to POLL_WAIT; pending tracks the drain length.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            poll_cnt <= '0;
            pending  <= '0;
        end else begin
            if (next_state == ST_POLL_WAIT && state != ST_POLL_WAIT) begin
                poll_cnt <= POLL_LOAD;
            end else if (state == ST_POLL_WAIT && poll_cnt != 16'd0) begin
                poll_cnt <= poll_cnt - 16'd1;
            end

            if (state == ST_STAT_WAIT) begin
                pending <= avail;
            end else if (state == ST_MSG_WAIT) begin
                pending <= pending - 8'd1;
            end
        end
    end

    imgproc_msg_parser #(
        .HEADER_ID (RBB_ID)
    ) u_parser (
        .clk        (clk),
        .reset_n    (reset_n),
        .word       (m_readdata),
        .word_valid (word_valid),
        .bb_valid   (bb_valid),
        .bb_x_min   (bb_x_min),
        .bb_y_min   (bb_y_min),
        .bb_x_max   (bb_x_max),
        .bb_y_max   (bb_y_max),
        .bb_empty   (bb_empty),
        .err_count  (err_count)
    );

endmodule

// File: tb/tb_imgproc_msg_reader.sv
// Scoreboard bench for imgproc_msg_reader with a behavioural Avalon slave model.
module tb_imgproc_msg_reader;

    localparam int          P        = 8;
    localparam logic [31:0] GOOD_ID  = 32'h1234_EEE2;
    localparam logic [31:0] HDR      = 32'h0052_4242;

    typedef struct packed {
        logic [10:0] x0;
        logic [10:0] y0;
        logic [10:0] x1;
        logic [10:0] y1;
        logic        empty;
    } box_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        m_chipselect;
    logic        m_read;
    logic        m_write;
    logic [2:0]  m_address;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata = '0;
    logic        id_ok;
    logic        bb_valid;
    logic [10:0] bb_x_min, bb_y_min, bb_x_max, bb_y_max;
    logic        bb_empty;
    logic [7:0]  err_count;

    int          asserts = 0;
    int          fails   = 0;
    int          read_count = 0;
    int          write_count = 0;
    int          bb_count = 0;
    logic [2:0]  last_waddr = '0;
    logic [31:0] last_wdata = '0;
    logic [31:0] id_value;
    logic        prev_read = 1'b0;

    logic [31:0] stat_q[$];
    logic [31:0] msg_q[$];
    box_t        exp_q[$];

    always #5 clk = ~clk;

    imgproc_msg_reader #(
        .POLL_CYCLES (P),
        .EXPECTED_ID (GOOD_ID),
        .RBB_ID      (HDR)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .m_chipselect (m_chipselect),
        .m_read       (m_read),
        .m_write      (m_write),
        .m_address    (m_address),
        .m_writedata  (m_writedata),
        .m_readdata   (m_readdata),
        .id_ok        (id_ok),
        .bb_valid     (bb_valid),
        .bb_x_min     (bb_x_min),
        .bb_y_min     (bb_y_min),
        .bb_x_max     (bb_x_max),
        .bb_y_max     (bb_y_max),
        .bb_empty     (bb_empty),
        .err_count    (err_count)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        asserts++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] cnt);
        stat_q.push_back({16'h0, cnt, 8'h0});
    endtask

    task automatic pushWord(input logic [31:0] w);
        msg_q.push_back(w);
    endtask

    task automatic expectBox(input int x0, input int y0, input int x1, input int y1, input logic e);
        box_t b;
        b.x0 = 11'(x0);
        b.y0 = 11'(y0);
        b.x1 = 11'(x1);
        b.y1 = 11'(y1);
        b.empty = e;
        exp_q.push_back(b);
    endtask

    task automatic waitDrain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || msg_q.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, 32'(exp_q.size() + msg_q.size()), 32'd0);
        repeat (4) @(negedge clk);
    endtask

    // Slave model: registered read data, one cycle of latency.
    always @(posedge clk) begin
        if (m_read) begin
            read_count <= read_count + 1;
            case (m_address)
                3'd0:    m_readdata <= (stat_q.size() != 0) ? stat_q.pop_front() : 32'h0;
                3'd1:    m_readdata <= (msg_q.size() != 0) ? msg_q.pop_front() : 32'h0;
                3'd2:    m_readdata <= id_value;
                default: m_readdata <= 32'h0;
            endcase
        end
        if (m_write) begin
            write_count <= write_count + 1;
            last_waddr  <= m_address;
            last_wdata  <= m_writedata;
        end
    end

    // Bus protocol monitor: chipselect tracks strobes, reads never back-to-back.
    always @(negedge clk) begin
        if (reset_n) begin
            checkOutput("bus_protocol",
                        {30'h0, (m_chipselect != (m_read | m_write)), (m_read & prev_read)}, 32'd0);
        end
        prev_read = m_read;
    end

    // Scoreboard monitor: every published box must match the oldest expectation.
    always @(negedge clk) begin
        if (reset_n && bb_valid) begin
            bb_count++;
            if (exp_q.size() == 0) begin
                checkOutput("bb_unexpected", 32'd1, 32'd0);
            end else begin
                box_t e;
                e = exp_q.pop_front();
                checkOutput("bb_x_min", 32'(bb_x_min), 32'(e.x0));
                checkOutput("bb_y_min", 32'(bb_y_min), 32'(e.y0));
                checkOutput("bb_x_max", 32'(bb_x_max), 32'(e.x1));
                checkOutput("bb_y_max", 32'(bb_y_max), 32'(e.y1));
                checkOutput("bb_empty", 32'(bb_empty), 32'(e.empty));
            end
        end
    end

    initial begin
        int cycles;
        int snap;

        reset_n  = 1'b0;
        enable   = 1'b1;
        id_value = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);

        checkOutput("rst_m_read",       32'(m_read),       32'd0);
        checkOutput("rst_m_write",      32'(m_write),      32'd0);
        checkOutput("rst_m_chipselect", 32'(m_chipselect), 32'd0);
        checkOutput("rst_m_address",    32'(m_address),    32'd0);
        checkOutput("rst_m_writedata",  m_writedata,       32'd0);
        checkOutput("rst_id_ok",        32'(id_ok),        32'd0);
        checkOutput("rst_bb_valid",     32'(bb_valid),     32'd0);
        checkOutput("rst_bb_coords",    32'({bb_x_min, bb_y_min} | {bb_x_max, bb_y_max}), 32'd0);
        checkOutput("rst_err_count",    32'(err_count),    32'd0);

        $display("[TB] bad ID phase");
        reset_n = 1'b1;
        repeat (10000) @(negedge clk);
        checkOutput("badid_id_ok",  32'(id_ok),   32'd0);
        checkOutput("badid_reads",  32'(read_count),  32'd1);
        checkOutput("badid_writes", 32'(write_count), 32'd0);

        $display("[TB] startup phase");
        reset_n  = 1'b0;
        id_value = GOOD_ID;
        repeat (2) @(negedge clk);
        read_count  = 0;
        write_count = 0;
        reset_n = 1'b1;
        cycles = 0;
        while (!(m_read && m_address == 3'd0) && cycles < 200) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("first_stat_rd_cycles", 32'(cycles), 32'(4 + P));
        checkOutput("id_ok",       32'(id_ok),       32'd1);
        checkOutput("flush_writes", 32'(write_count), 32'd1);
        checkOutput("flush_addr",  32'(last_waddr),  32'd0);
        checkOutput("flush_data",  last_wdata,       32'h10);

        $display("[TB] single message");
        pushWord(HDR);
        pushWord({5'b0, 11'd100, 5'b0, 11'd50});
        pushWord({5'b0, 11'd200, 5'b0, 11'd120});
        expectBox(100, 50, 200, 120, 1'b0);
        applyStimulus(8'd3);
        waitDrain("single_drain");

        $display("[TB] empty box");
        pushWord(HDR);
        pushWord({5'h1F, 11'd639, 5'h1F, 11'd479});
        pushWord({5'h15, 11'd0, 5'h0A, 11'd0});
        expectBox(639, 479, 0, 0, 1'b1);
        applyStimulus(8'd3);
        waitDrain("empty_drain");

        $display("[TB] resync");
        snap = bb_count;
        pushWord(32'd7);
        pushWord(32'd9);
        pushWord(HDR);
        pushWord({5'b0, 11'd10, 5'b0, 11'd20});
        pushWord({5'b0, 11'd30, 5'b0, 11'd40});
        expectBox(10, 20, 30, 40, 1'b0);
        applyStimulus(8'd5);
        waitDrain("resync_drain");
        checkOutput("resync_err_count", 32'(err_count), 32'd2);
        checkOutput("resync_bb_count",  32'(bb_count - snap), 32'd1);

        $display("[TB] split message");
        snap = bb_count;
        pushWord(HDR);
        pushWord({5'b0, 11'd1, 5'b0, 11'd2});
        pushWord({5'b0, 11'd3, 5'b0, 11'd4});
        expectBox(1, 2, 3, 4, 1'b0);
        applyStimulus(8'd2);
        applyStimulus(8'd1);
        cycles = 0;
        while (msg_q.size() != 1 && cycles < 500) begin
            @(negedge clk);
            cycles++;
        end
        repeat (4) @(negedge clk);
        checkOutput("split_first_drain_left", 32'(msg_q.size()), 32'd1);
        checkOutput("split_no_early_bb", 32'(bb_count - snap), 32'd0);
        waitDrain("split_drain");
        checkOutput("split_bb_count", 32'(bb_count - snap), 32'd1);

        $display("[TB] enable hold");
        enable = 1'b0;
        repeat (3 * P + 20) @(negedge clk);
        snap = read_count;
        repeat (200) @(negedge clk);
        checkOutput("hold_no_reads", 32'(read_count - snap), 32'd0);
        enable = 1'b1;
        repeat (3 * P) @(negedge clk);
        checkOutput("resume_reads", 32'(read_count > snap), 32'd1);

        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
